// File: rtl/uart_frame_sequencer.sv
// UART frame-position sequencer: walks START/DATA/PARITY/STOP one bit per baud tick.
// Optional macro FRAME_SEQ_PARITY_EN enables the PARITY phase; otherwise cfg_parity_en_i is ignored.
module uart_frame_sequencer #(
  parameter int MAX_DATA_BITS = 9,
  parameter int IDX_W         = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [IDX_W-1:0] cfg_data_bits_i,
  input  logic             cfg_parity_en_i,
  input  logic             cfg_stop2_i,
  output logic [2:0]       phase_o,
  output logic [IDX_W-1:0] frame_index_o,
  output logic [IDX_W-1:0] data_index_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             frame_end_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } phase_t;

  localparam logic [IDX_W-1:0] MIN_LEN = IDX_W'(5);
  localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(MAX_DATA_BITS);
  localparam logic [IDX_W-1:0] RST_LEN = IDX_W'(8);

  phase_t           phase_q, phase_d;
  logic [IDX_W-1:0] frame_idx_q, frame_idx_d;
  logic [IDX_W-1:0] data_idx_q, data_idx_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic             par_q, par_d;
  logic             stop2_q, stop2_d;
  logic             second_q, second_d;
  logic             frame_end_q, frame_end_d;

  logic [IDX_W-1:0] len_clamped;
  logic             par_cfg;
  logic             final_tick;

  always_comb begin
    len_clamped = cfg_data_bits_i;
    if (cfg_data_bits_i < MIN_LEN)      len_clamped = MIN_LEN;
    else if (cfg_data_bits_i > MAX_LEN) len_clamped = MAX_LEN;
  end

`ifdef FRAME_SEQ_PARITY_EN
  assign par_cfg = cfg_parity_en_i;
`else
  assign par_cfg = cfg_parity_en_i & 1'b0;
`endif

  // Last stop bit being consumed: the only non-IDLE point where a new start is honoured.
  assign final_tick = en_i && (phase_q == ST_STOP) && !(stop2_q && !second_q);

  always_comb begin
    phase_d     = phase_q;
    frame_idx_d = frame_idx_q;
    data_idx_d  = data_idx_q;
    len_d       = len_q;
    par_d       = par_q;
    stop2_d     = stop2_q;
    second_d    = second_q;
    frame_end_d = 1'b0;

    if ((phase_q != ST_IDLE) && abort_i) begin
      phase_d     = ST_IDLE;
      frame_idx_d = '0;
      data_idx_d  = '0;
      second_d    = 1'b0;
    end else if ((phase_q == ST_IDLE) || final_tick) begin
      if (final_tick) begin
        frame_end_d = 1'b1;
        phase_d     = ST_IDLE;
        frame_idx_d = '0;
        data_idx_d  = '0;
        second_d    = 1'b0;
      end
      if (start_i) begin
        phase_d     = ST_START;
        frame_idx_d = '0;
        data_idx_d  = '0;
        second_d    = 1'b0;
        len_d       = len_clamped;
        par_d       = par_cfg;
        stop2_d     = cfg_stop2_i;
      end
    end else if (en_i) begin
      frame_idx_d = frame_idx_q + IDX_W'(1);
      case (phase_q)
        ST_START: begin
          phase_d    = ST_DATA;
          data_idx_d = '0;
        end
        ST_DATA: begin
          if (data_idx_q == len_q - IDX_W'(1)) begin
            phase_d    = par_q ? ST_PARITY : ST_STOP;
            data_idx_d = '0;
          end else begin
            data_idx_d = data_idx_q + IDX_W'(1);
          end
        end
        ST_PARITY: phase_d  = ST_STOP;
        ST_STOP:   second_d = 1'b1;
        default: begin
          phase_d     = ST_IDLE;
          frame_idx_d = '0;
          data_idx_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q     <= ST_IDLE;
      frame_idx_q <= '0;
      data_idx_q  <= '0;
      len_q       <= RST_LEN;
      par_q       <= 1'b0;
      stop2_q     <= 1'b0;
      second_q    <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      frame_idx_q <= frame_idx_d;
      data_idx_q  <= data_idx_d;
      len_q       <= len_d;
      par_q       <= par_d;
      stop2_q     <= stop2_d;
      second_q    <= second_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign phase_o       = phase_q;
  assign frame_index_o = frame_idx_q;
  assign data_index_o  = data_idx_q;
  assign busy_o        = (phase_q != ST_IDLE);
  assign done_o        = (phase_q == ST_IDLE);
  assign frame_end_o   = frame_end_q;

endmodule

// File: doc/uart_frame_sequencer.md
# uart_frame_sequencer

- Parametrised UART frame-position sequencer: successor to the fixed-length bit-index counter.
- Steps through IDLE, START, DATA, PARITY and STOP phases, advancing one bit per baud tick.
- Data length, parity and stop-bit count are configured per frame.
- Sits between the baud generator and the TX shift/serialiser (and the RX sampler); exposes phase, frame position, data-bit index and busy/done/frame_end status.

## Interface
- MAX_DATA_BITS, 9: largest supported data length; legal range 5..9.
- IDX_W, 4: width of the index and config ports; must satisfy 2^IDX_W > MAX_DATA_BITS+3.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  baud tick, one clk wide; advances the sequence.
- start  in  1  frame request, accepted only in IDLE.
- abort  in  1  cancels the frame in progress.
- cfg_data_bits  in  IDX_W  data length; latched at acceptance.
- cfg_parity_en  in  1  insert a parity bit; latched at acceptance.
- cfg_stop2  in  1  two stop bits instead of one; latched at acceptance.
- phase  out  3  IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- frame_index  out  IDX_W  bit position within the frame, 0 = start bit.
- data_index  out  IDX_W  current data bit, LSB first; 0 outside DATA.
- busy  out  1  high in every phase except IDLE.
- done  out  1  high in IDLE, i.e. ~busy.
- frame_end  out  1  one-cycle pulse when a frame completes normally.

## Operation
- Reset values: phase=IDLE, frame_index=0, data_index=0, busy=0, done=1, frame_end=0; latched config = 8 data bits, no parity, 1 stop bit.
- Priority, highest first: rst > abort > start/en.
- IDLE, start=1:
  - latch config; clamp cfg_data_bits below 5 to 5 and above MAX_DATA_BITS to MAX_DATA_BITS;
  - go to START with frame_index=0.
- Any en in the acceptance cycle is ignored.
- Each non-IDLE phase holds until the next en. On en:
  - START -> DATA, data_index=0.
  - DATA: if data_index == len-1, go to PARITY when parity is enabled, else STOP; otherwise data_index+1.
  - PARITY -> STOP.
  - STOP, first stop bit with stop2 latched -> second stop bit (phase stays STOP).
  - STOP, final stop bit -> IDLE and pulse frame_end.
- frame_index increments on every en outside IDLE and returns to 0 in IDLE; it never wraps within a legal frame.
- Back-to-back frames: start high in the cycle of the final en:
  - go directly to START with frame_index=0 and new config latched;
  - frame_end still pulses;
  - done does not go high.
- abort in a non-IDLE phase: IDLE next cycle, indices cleared, no frame_end. abort in IDLE has no effect.
- start in a non-IDLE phase is ignored (not queued), except in the final-en cycle described above.
- Config inputs are ignored except in the acceptance cycle.

## Timing
- All outputs are registered; they update on the clk edge after the triggering inputs.
- Latency:
  - start -> busy=1, phase=START: 1 cycle;
  - final en -> frame_end=1, done=1: 1 cycle;
  - frame_end lasts exactly 1 cycle.
- Frame length in en ticks after acceptance: 1 + len + parity + (stop2 ? 2 : 1). Range 7..13 ticks (8N1 = 10).
- rst mid-frame: reset values next cycle; no frame_end.
- en held high continuously: one advance per clk cycle. Legal; used for fast simulation.

## Configuration
- FRAME_SEQ_PARITY_EN defined: PARITY phase implemented, controlled by cfg_parity_en.
- Undefined:
  - cfg_parity_en is ignored (port retained);
  - phase never takes value 3;
  - frame length = 1 + len + stop bits.

## Test plan
- 8N1: cfg 8/0/0, start, 10 en ticks -> phases START, DATA x8 (data_index 0..7), STOP; frame_index 0..9; frame_end one cycle after tick 10; done=1.
- 7E2 with macro: cfg 7/1/1 -> 7 DATA ticks, 1 PARITY, 2 STOP; frame_end after tick 11. Without macro: no PARITY; frame_end after tick 10.
- Clamping: cfg_data_bits=2 -> 5 DATA ticks; cfg_data_bits=15 -> 9 DATA ticks.
- Back-to-back: start asserted with the final en -> frame_end=1, phase=START next cycle, done stays 0; new config takes effect in frame 2.
- Abort at data_index=3 -> next cycle IDLE, indices 0, no frame_end. rst at frame_index=5 -> reset values next cycle.
- start during DATA ignored; start and en in the same IDLE cycle -> START, frame_index 0, not advanced.
